// File: rtl/ctrl_word_sequencer_if.sv
// rtl/ctrl_word_sequencer_if.sv - request and control-word handshake bundle for ctrl_word_sequencer
// master drives requests and accepts words; slave is the sequencer.
interface ctrl_word_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [3:0] req_len;
  logic       cw_valid;
  logic       cw_ready;
  logic [6:0] cw;

  modport master (
    output req_valid, req_op, req_len, cw_ready,
    input  req_ready, cw_valid, cw
  );

  modport slave (
    input  req_valid, req_op, req_len, cw_ready,
    output req_ready, cw_valid, cw
  );
endinterface

// File: rtl/ctrl_word_sequencer.sv
// rtl/ctrl_word_sequencer.sv - expands buffered requests into prologue/body/epilogue control words
// Requests sit in a 2-entry FIFO; a single FSM issues one registered word per accepted handshake.
module ctrl_word_sequencer (
  input  logic                   clk,
  input  logic                   rst_n,
  ctrl_word_sequencer_if.slave   bus,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);
  localparam int FIFO_DEPTH = 2;
  localparam logic [1:0] PH_PRO  = 2'b01;
  localparam logic [1:0] PH_BODY = 2'b10;
  localparam logic [1:0] PH_EPI  = 2'b11;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {IDLE, PRO, BODY, EPI} state_t;

  state_t     state;
  logic [6:0] fifo_mem [FIFO_DEPTH];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic [2:0] op_q;
  logic [3:0] cnt;
  logic       cw_valid_q;
  logic [6:0] cw_q;

  logic       empty;
  logic       full;
  logic       hs;
  logic       reserved;
  logic       push;
  logic       pop;
  logic       accept;
  logic [2:0] head_op;
  logic [3:0] head_len;
  logic [3:0] cnt_dec;

  assign empty    = (count == 2'd0);
  assign full     = (count == 2'(FIFO_DEPTH));
  assign hs       = bus.req_valid & ~full;
  assign reserved = (bus.req_op == OP_RSVD);
  assign push     = hs & ~reserved & ~abort;
  assign accept   = cw_valid_q & bus.cw_ready;
  // EPI pops on its own acceptance so back-to-back requests run without a bubble
  assign pop      = ~empty & ~abort & ((state == IDLE) | ((state == EPI) & accept));
  assign head_op  = fifo_mem[rd_ptr][6:4];
  assign head_len = fifo_mem[rd_ptr][3:0];
  assign cnt_dec  = cnt - 4'd1;

  assign bus.req_ready = ~full;
  assign bus.cw_valid  = cw_valid_q;
  assign bus.cw        = cw_q;
  assign busy          = (state != IDLE) | ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= 7'h00;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      op_q       <= 3'd0;
      cnt        <= 4'd0;
      cw_valid_q <= 1'b0;
      cw_q       <= 7'h00;
      done       <= 1'b0;
      err        <= 1'b0;
    end else if (abort) begin
      state      <= IDLE;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      cw_valid_q <= 1'b0;
      cw_q       <= 7'h00;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= hs & reserved;
      if (push) begin
        fifo_mem[wr_ptr] <= {bus.req_op, bus.req_len};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);

      case (state)
        IDLE: begin
          if (!empty) begin
            state      <= PRO;
            op_q       <= head_op;
            cnt        <= head_len;
            cw_valid_q <= 1'b1;
            cw_q       <= {head_op, PH_PRO, 2'b00};
          end
        end
        PRO, BODY: begin
          // cnt tracks body words still owed after the word being issued
          if (accept) begin
            if (cnt != 4'd0) begin
              state <= BODY;
              cnt   <= cnt_dec;
              cw_q  <= {op_q, PH_BODY, cnt_dec[1:0]};
            end else begin
              state <= EPI;
              cw_q  <= {op_q, PH_EPI, 2'b00};
            end
          end
        end
        EPI: begin
          if (accept) begin
            done <= 1'b1;
            if (!empty) begin
              state <= PRO;
              op_q  <= head_op;
              cnt   <= head_len;
              cw_q  <= {head_op, PH_PRO, 2'b00};
            end else begin
              state      <= IDLE;
              cw_valid_q <= 1'b0;
              cw_q       <= 7'h00;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
